// File: rtl/dp_iso_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dp_iso_pkg
//  Purpose  : Shared definitions for the DP isochronous lane scheduler.
//             - FSM state encoding
//             - main-link control symbol codes
//             - lane-count encodings, mux select codes
//             - lane-count to active-lane mask helper
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dp_iso_pkg;

    localparam int NUM_LANES = 4;

    // Scheduler FSM state encoding
    typedef logic [2:0] iso_state_t;
    localparam iso_state_t ST_IDLE   = 3'd0;
    localparam iso_state_t ST_BE     = 3'd1;
    localparam iso_state_t ST_ACTIVE = 3'd2;
    localparam iso_state_t ST_BS     = 3'd3;
    localparam iso_state_t ST_BLANK  = 3'd4;

    // Main-link symbol codes (K codes carry the control flag)
    localparam logic [7:0] BE_SYM    = 8'hFB;
    localparam logic [7:0] BS_SYM    = 8'hBC;
    localparam logic [7:0] SR_SYM    = 8'h1C;
    localparam logic [7:0] DUMMY_SYM = 8'h00;

    // cfg_lane_count encodings; code 2 is not a legal DP width and maps to 4
    localparam logic [1:0] LC_1LANE     = 2'd0;
    localparam logic [1:0] LC_2LANE     = 2'd1;
    localparam logic [1:0] LC_4LANE_ALT = 2'd2;
    localparam logic [1:0] LC_4LANE     = 2'd3;

    // Per-lane symbol source select
    typedef logic [1:0] lane_sel_t;
    localparam lane_sel_t SEL_DUMMY = 2'd0;
    localparam lane_sel_t SEL_DATA  = 2'd1;
    localparam lane_sel_t SEL_CTRL  = 2'd2;

    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] lane_count);
        logic [NUM_LANES-1:0] mask;
        case (lane_count)
            LC_1LANE: mask = 4'b0001;
            LC_2LANE: mask = 4'b0011;
            default:  mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dp_iso_lane_mux.sv
`default_nettype none
// ============================================================================
//  Module   : dp_iso_lane_mux
//  Purpose  : Combinational per-lane symbol selector. Each enabled lane
//             carries either its byte of the pixel word, the shared control
//             symbol (flagged as K code) or the dummy symbol. Disabled lanes
//             are forced to 0 with flag 0.
//  Ports    : i_sel       - symbol source select (dummy/data/control)
//             i_ctrl_sym  - control symbol for all enabled lanes
//             i_data      - pixel word, byte k for lane k
//             i_lane_en   - active-lane mask
//             o_lane_sym  - per-lane symbol
//             o_lane_flag - per-lane control-symbol flag
//  Revision : 1.0 - initial release
// ============================================================================
module dp_iso_lane_mux
    import dp_iso_pkg::*;
#(
    parameter int AUX_DATA_WIDTH = 8
) (
    input  lane_sel_t                                   i_sel,
    input  logic [AUX_DATA_WIDTH-1:0]                   i_ctrl_sym,
    input  logic [NUM_LANES*AUX_DATA_WIDTH-1:0]         i_data,
    input  logic [NUM_LANES-1:0]                        i_lane_en,
    output logic [NUM_LANES-1:0][AUX_DATA_WIDTH-1:0]    o_lane_sym,
    output logic [NUM_LANES-1:0]                        o_lane_flag
);

    localparam logic [AUX_DATA_WIDTH-1:0] c_DUMMY = AUX_DATA_WIDTH'(DUMMY_SYM);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign o_lane_sym[i]  = !i_lane_en[i]        ? '0 :
                                (i_sel == SEL_DATA)  ? i_data[i*AUX_DATA_WIDTH +: AUX_DATA_WIDTH] :
                                (i_sel == SEL_CTRL)  ? i_ctrl_sym :
                                                       c_DUMMY;
        assign o_lane_flag[i] = i_lane_en[i] && (i_sel == SEL_CTRL);
    end

endmodule
`default_nettype wire

// File: rtl/dp_iso_lane_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dp_iso_lane_scheduler
//  Purpose  : Frames each video line of the isochronous main-link stream as
//             BE, active pixel words, BS (or SR), blanking, and spreads the
//             accepted pixel bytes over 1, 2 or 4 lanes. All lane outputs
//             are registered: the symbol chosen while the FSM sits in a
//             state appears on the lanes one cycle later.
//  Macro    : ISO_SR_INSERT_EN - when defined, every SR_PERIOD-th BS slot
//             (starting with the first after reset) carries SR instead.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             cfg_en                     - enable line generation
//             cfg_lane_count             - 0:1 lane, 1:2 lanes, 2/3:4 lanes
//             cfg_active_syms            - active words per line
//             cfg_blank_syms             - blanking symbols per line
//             in_data, in_valid, in_ready- pixel word stream
//             iso_symbols_lane0..3       - per-lane output symbol
//             control_sym_flag_lane0..3  - per-lane K-code flag
//             line_done                  - pulse with last blanking symbol
//             underflow                  - pulse with each stall symbol
//  Revision : 1.0 - initial release
// ============================================================================
module dp_iso_lane_scheduler
    import dp_iso_pkg::*;
#(
    parameter int AUX_DATA_WIDTH = 8,
    parameter int CNT_W          = 16,
    parameter int SR_PERIOD      = 512
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_en,
    input  logic [1:0]                    cfg_lane_count,
    input  logic [CNT_W-1:0]              cfg_active_syms,
    input  logic [CNT_W-1:0]              cfg_blank_syms,
    input  logic [4*AUX_DATA_WIDTH-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [AUX_DATA_WIDTH-1:0]     iso_symbols_lane0,
    output logic [AUX_DATA_WIDTH-1:0]     iso_symbols_lane1,
    output logic [AUX_DATA_WIDTH-1:0]     iso_symbols_lane2,
    output logic [AUX_DATA_WIDTH-1:0]     iso_symbols_lane3,
    output logic                          control_sym_flag_lane0,
    output logic                          control_sym_flag_lane1,
    output logic                          control_sym_flag_lane2,
    output logic                          control_sym_flag_lane3,
    output logic                          line_done,
    output logic                          underflow
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State and shadow configuration
    // ------------------------------------------------------------------
    iso_state_t             r_state;
    iso_state_t             w_next_state;
    logic [1:0]             r_lane_count;
    logic [CNT_W-1:0]       r_active_syms;
    logic [CNT_W-1:0]       r_blank_syms;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_active_last;
    logic                   w_blank_last;
    logic                   w_accept;
    logic                   w_stall;
    logic                   w_line_done;
    lane_sel_t              w_sel;
    logic [7:0]             w_ctrl_sym;
    logic [7:0]             w_bs_sym;

    logic [NUM_LANES-1:0][AUX_DATA_WIDTH-1:0] w_lane_sym;
    logic [NUM_LANES-1:0]                     w_lane_flag;
    logic [NUM_LANES-1:0][AUX_DATA_WIDTH-1:0] r_lane_sym;
    logic [NUM_LANES-1:0]                     r_lane_flag;
    logic                                     r_in_ready;
    logic                                     r_line_done;
    logic                                     r_underflow;

    // A count of zero never reaches these compares: BE skips ACTIVE and
    // BS skips BLANK in that case.
    assign w_active_last = (r_cnt == (r_active_syms - c_ONE));
    assign w_blank_last  = (r_cnt == (r_blank_syms  - c_ONE));

    // ------------------------------------------------------------------
    // BS slot symbol: optionally replaced by SR on a fixed cadence
    // ------------------------------------------------------------------
`ifdef ISO_SR_INSERT_EN
    localparam int               c_SR_W    = (SR_PERIOD > 1) ? $clog2(SR_PERIOD) : 1;
    localparam logic [c_SR_W-1:0] c_SR_LAST = c_SR_W'(SR_PERIOD - 1);

    logic [c_SR_W-1:0] r_sr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_cnt <= '0;
        end else if (r_state == ST_BS) begin
            r_sr_cnt <= (r_sr_cnt == c_SR_LAST) ? '0 : r_sr_cnt + 1'b1;
        end
    end

    assign w_bs_sym = (r_sr_cnt == '0) ? SR_SYM : BS_SYM;
`else
    assign w_bs_sym = BS_SYM;

    // SR_PERIOD only shapes the SR cadence; a non-positive value is never
    // meaningful, so it is referenced here to keep the parameter checked.
    if (SR_PERIOD < 1) begin : g_sr_period_invalid
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_sel        = SEL_DUMMY;
        w_ctrl_sym   = BE_SYM;
        w_accept     = 1'b0;
        w_stall      = 1'b0;
        w_line_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_en) begin
                    w_next_state = ST_BE;
                end
            end
            ST_BE: begin
                w_sel        = SEL_CTRL;
                w_ctrl_sym   = BE_SYM;
                w_next_state = (r_active_syms == '0) ? ST_BS : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_sel    = SEL_DATA;
                    if (w_active_last) begin
                        w_next_state = ST_BS;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_BS: begin
                w_sel      = SEL_CTRL;
                w_ctrl_sym = w_bs_sym;
                if (r_blank_syms == '0) begin
                    w_next_state = cfg_en ? ST_BE : ST_IDLE;
                end else begin
                    w_next_state = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (w_blank_last) begin
                    w_line_done  = 1'b1;
                    w_next_state = cfg_en ? ST_BE : ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow config: only IDLE follows the live cfg_* inputs, so a line
    // in flight is immune to configuration changes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_count  <= LC_1LANE;
            r_active_syms <= '0;
            r_blank_syms  <= '0;
        end else if (r_state == ST_IDLE) begin
            r_lane_count  <= cfg_lane_count;
            r_active_syms <= cfg_active_syms;
            r_blank_syms  <= cfg_blank_syms;
        end
    end

    // Shared ACTIVE/BLANK counter; holds across ACTIVE stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (w_accept) begin
                        r_cnt <= w_active_last ? '0 : r_cnt + c_ONE;
                    end
                end
                ST_BLANK: begin
                    r_cnt <= w_blank_last ? '0 : r_cnt + c_ONE;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lane selection and output registers
    // ------------------------------------------------------------------
    dp_iso_lane_mux #(
        .AUX_DATA_WIDTH (AUX_DATA_WIDTH)
    ) u_lane_mux (
        .i_sel       (w_sel),
        .i_ctrl_sym  (AUX_DATA_WIDTH'(w_ctrl_sym)),
        .i_data      (in_data),
        .i_lane_en   (lane_mask(r_lane_count)),
        .o_lane_sym  (w_lane_sym),
        .o_lane_flag (w_lane_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_sym  <= '0;
            r_lane_flag <= '0;
            r_in_ready  <= 1'b0;
            r_line_done <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_lane_sym  <= w_lane_sym;
            r_lane_flag <= w_lane_flag;
            // Registered from the next state so it is high exactly while
            // the FSM sits in ACTIVE.
            r_in_ready  <= (w_next_state == ST_ACTIVE);
            r_line_done <= w_line_done;
            r_underflow <= w_stall;
        end
    end

    assign in_ready               = r_in_ready;
    assign line_done              = r_line_done;
    assign underflow              = r_underflow;
    assign iso_symbols_lane0      = r_lane_sym[0];
    assign iso_symbols_lane1      = r_lane_sym[1];
    assign iso_symbols_lane2      = r_lane_sym[2];
    assign iso_symbols_lane3      = r_lane_sym[3];
    assign control_sym_flag_lane0 = r_lane_flag[0];
    assign control_sym_flag_lane1 = r_lane_flag[1];
    assign control_sym_flag_lane2 = r_lane_flag[2];
    assign control_sym_flag_lane3 = r_lane_flag[3];

endmodule
`default_nettype wire
